// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_pkg
// Description : Shared types and defaults for the register-file write arbiter
//               and the register file it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    // Width defaults shared with the register file so both sides agree.
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 3;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Debug owner encodings.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // Map a state to its debug owner code.
    function automatic logic [1:0] owner_of(input arb_state_e s);
        case (s)
            OWN0:    owner_of = OWNER_M0;
            OWN1:    owner_of = OWNER_M1;
            default: owner_of = OWNER_NONE;
        endcase
    endfunction

endpackage : rf_write_arbiter_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way picker. A forced owner bit restricts the
//               grant to that master; otherwise prio breaks a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       prio,
    input  logic [1:0] force_owner,
    output logic [1:0] gnt
);

    // One-hot grant; a forced owner blocks the other master entirely.
    always_comb begin
        gnt = 2'b00;
        if (force_owner[0]) begin
            gnt[0] = req0;
        end else if (force_owner[1]) begin
            gnt[1] = req1;
        end else begin
            gnt[0] = req0 & (~req1 | ~prio);
            gnt[1] = req1 & (~req0 |  prio);
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter of two write masters onto the single
//               register-file write port, with a bounded ownership lock and
//               one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0] wData,
    output logic [1:0]            owner
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e            state_q, state_d;
    logic                  prio_q, prio_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            owner_q;

    logic       owned;      // current owner is still requesting
    logic       arb_prio;   // priority used when arbitrating freely
    logic [1:0] force_vec;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       win;        // 1 when master 1 wins
    logic       lock_win;

    // Ownership holds only while the owner keeps requesting; a dropped
    // request releases it immediately and hands priority to the other side.
    always_comb begin
        owned     = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);
        force_vec = {(state_q == OWN1) && req1, (state_q == OWN0) && req0};
        if (state_q == OWN0)      arb_prio = 1'b1;
        else if (state_q == OWN1) arb_prio = 1'b0;
        else                      arb_prio = prio_q;
    end

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .prio        (arb_prio),
        .force_owner (force_vec),
        .gnt         (pick)
    );

    // Grants are suppressed during reset so the master retries later.
    always_comb begin
        gnt      = reset ? 2'b00 : pick;
        win      = gnt[1];
        lock_win = win ? lock1 : lock0;
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Next state, priority pointer and lock counter.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (owned) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!lock_win || (cnt_d == CNT_W'(MAX_LOCK))) begin
                state_d = IDLE;
                prio_d  = ~win;
                cnt_d   = '0;
            end
        end else if (gnt != 2'b00) begin
            prio_d = ~win;
            if (lock_win) begin
                state_d = win ? OWN1 : OWN0;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            state_d = IDLE;
            prio_d  = arb_prio;
            cnt_d   = '0;
        end
    end

    // State registers and the registered write-port stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            owner_q <= OWNER_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_of(state_d);
            we_q    <= (gnt != 2'b00);
            if (gnt != 2'b00) begin
                waddr_q <= win ? addr1 : addr0;
                wdata_q <= win ? data1 : data0;
            end
        end
    end

    assign we    = we_q;
    assign wAddr = waddr_q;
    assign wData = wdata_q;
    assign owner = owner_q;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter with a write
//               scoreboard and a small register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, we;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [DW-1:0] mem [8];

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .addr0 (addr0),
        .addr1 (addr1),
        .data0 (data0),
        .data1 (data1),
        .lock0 (lock0),
        .lock1 (lock1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .we    (we),
        .wAddr (wAddr),
        .wData (wData),
        .owner (owner)
    );

    always #5 clk = ~clk;

    function automatic wr_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    // Scoreboard: each register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got addr=%0d data=%h, none expected", wAddr, wData);
            end else begin
                mon_e = exp_q.pop_front();
                if (wAddr !== mon_e.a || wData !== mon_e.d) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h expected addr=%0d data=%h",
                             wAddr, wData, mon_e.a, mon_e.d);
                end
            end
            mem[wAddr] = wData;
        end
    end

    task automatic set_req(input logic r0, input logic l0, input logic r1, input logic l1);
        req0  = r0;
        lock0 = l0;
        req1  = r1;
        lock1 = l1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        addr0 = 3'd1; data0 = 32'h1;
        addr1 = 3'd2; data1 = 32'h2;
        for (int i = 0; i < 2; i++) begin
            mid_cycle();
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt cycle %0d got gnt1,gnt0=%b%b expected 00", i, gnt1, gnt0);
            end
            next_cycle();
        end
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", we); end
        checks++;
        if (wAddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0d expected 0", wAddr); end
        checks++;
        if (wData !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h expected 0", wData); end
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b expected 00", owner); end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_alternation();
        logic e0;
        addr0 = 3'd3; data0 = 32'hAAAA0000;
        addr1 = 3'd5; data1 = 32'h0000BBBB;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid_cycle();
            e0 = (i % 2 == 0);
            checks++;
            if (gnt0 !== e0 || gnt1 !== !e0) begin
                errors++;
                $display("FAIL alt_gnt cycle %0d got gnt1,gnt0=%b%b expected %b%b", i, gnt1, gnt0, !e0, e0);
            end
            if (i > 0) begin
                checks++;
                if (we !== 1'b1) begin errors++; $display("FAIL alt_we cycle %0d got %b expected 1", i, we); end
            end
            if (e0) exp_q.push_back(mk(3'd3, 32'hAAAA0000));
            else    exp_q.push_back(mk(3'd5, 32'h0000BBBB));
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
    endtask

    task automatic test_lock_cap();
        logic       e0;
        logic [1:0] eo;
        addr0 = 3'd1; data0 = 32'h01010101;
        addr1 = 3'd2; data1 = 32'h02020202;
        set_req(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mid_cycle();
            e0 = (i < 4);
            eo = (i >= 1 && i <= 3) ? 2'b01 : 2'b00;
            checks++;
            if (gnt0 !== e0 || gnt1 !== !e0) begin
                errors++;
                $display("FAIL lock_gnt cycle %0d got gnt1,gnt0=%b%b expected %b%b", i, gnt1, gnt0, !e0, e0);
            end
            checks++;
            if (owner !== eo) begin
                errors++;
                $display("FAIL lock_owner cycle %0d got %b expected %b", i, owner, eo);
            end
            if (e0) exp_q.push_back(mk(3'd1, 32'h01010101));
            else    exp_q.push_back(mk(3'd2, 32'h02020202));
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
    endtask

    task automatic test_early_release();
        addr0 = 3'd4; data0 = 32'h44;
        addr1 = 3'd7; data1 = 32'h77;
        set_req(1'b1, 1'b1, 1'b1, 1'b0);
        mid_cycle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL rel_first_gnt got gnt1,gnt0=%b%b expected 01", gnt1, gnt0);
        end
        exp_q.push_back(mk(3'd4, 32'h44));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        mid_cycle();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            errors++; $display("FAIL rel_switch_gnt got gnt1,gnt0=%b%b expected 10", gnt1, gnt0);
        end
        checks++;
        if (owner !== 2'b01) begin errors++; $display("FAIL rel_owner_held got %b expected 01", owner); end
        exp_q.push_back(mk(3'd7, 32'h77));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        mid_cycle();
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL rel_owner_free got %b expected 00", owner); end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL rel_idle_gnt got gnt1,gnt0=%b%b expected 00", gnt1, gnt0);
        end
        next_cycle();
        repeat (1) next_cycle();
    endtask

    task automatic test_same_addr();
        addr0 = 3'd6; data0 = 32'h11;
        addr1 = 3'd6; data1 = 32'h22;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        mid_cycle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL same_first_gnt got gnt1,gnt0=%b%b expected 01", gnt1, gnt0);
        end
        exp_q.push_back(mk(3'd6, 32'h11));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        mid_cycle();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            errors++; $display("FAIL same_second_gnt got gnt1,gnt0=%b%b expected 10", gnt1, gnt0);
        end
        exp_q.push_back(mk(3'd6, 32'h22));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        checks++;
        if (mem[6] !== 32'h22) begin errors++; $display("FAIL same_final_reg6 got %h expected 00000022", mem[6]); end
        checks++;
        if (wData !== 32'h22) begin errors++; $display("FAIL same_wdata_hold got %h expected 00000022", wData); end
    endtask

    task automatic test_reset_mid_burst();
        addr0 = 3'd0; data0 = 32'hCAFE0000;
        addr1 = 3'd2; data1 = 32'h00005555;
        set_req(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            mid_cycle();
            checks++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                errors++; $display("FAIL mid_own_gnt cycle %0d got gnt1,gnt0=%b%b expected 10", i, gnt1, gnt0);
            end
            exp_q.push_back(mk(3'd2, 32'h00005555));
            next_cycle();
        end
        reset = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 1'b1);
        mid_cycle();
        checks++;
        if (owner !== 2'b10) begin errors++; $display("FAIL mid_owner_before got %b expected 10", owner); end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL mid_reset_gnt got gnt1,gnt0=%b%b expected 00", gnt1, gnt0);
        end
        next_cycle();
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL mid_reset_we got %b expected 0", we); end
        checks++;
        if (owner !== 2'b00) begin errors++; $display("FAIL mid_reset_owner got %b expected 00", owner); end
        reset = 1'b0;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        mid_cycle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL mid_after_gnt got gnt1,gnt0=%b%b expected 01", gnt1, gnt0);
        end
        exp_q.push_back(mk(3'd0, 32'hCAFE0000));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
    endtask

    // Bound the whole run so a stuck design cannot hang the simulation.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_alternation();
        test_lock_cap();
        test_early_release();
        test_same_addr();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending writes expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
